// File: rtl/matrix_glyph_source.sv
// Glyph ROM pixel source for an 8x8 APA102 matrix: streams 64 LED words per frame
// in strip order over valid/ready, with serpentine row mapping and fg/bg colouring.
module matrix_glyph_source #(
   parameter int WIDTH      = 8,
   parameter int HEIGHT     = 8,
   parameter int NUM_GLYPHS = 4,
   parameter bit SERPENTINE = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  glyph_sel,
   input  logic [31:0] fg_color,
   input  logic [31:0] bg_color,
   output logic        busy,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [31:0] pix_data,
   output logic [5:0]  pix_index,
   output logic        pix_last,
   output logic        done
);

   localparam int NUM_LEDS = WIDTH * HEIGHT;
   localparam logic [5:0] LAST_IDX = 6'(NUM_LEDS - 1);

   // Row-major, MSB-first: bit 63 is row 0 col 0, each byte is one row.
   localparam logic [63:0] GLYPH_ROM [4] = '{
      64'h0000780C7CCC7600,
      64'h0706063E66663B00,
      64'h00001E3303331E00,
      64'h3830303E33336E00
   };

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_STREAM
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic [31:0] fg_q, fg_d;
   logic [31:0] bg_q, bg_d;
   logic [63:0] shadow_q, shadow_d;
   logic        busy_q, busy_d;
   logic        valid_q, valid_d;
   logic [31:0] data_q, data_d;
   logic [5:0]  index_q, index_d;
   logic        last_q, last_d;
   logic        done_q, done_d;

   // Shadow bits reordered into strip order so a pixel is a single indexed lookup.
   logic [63:0] strip_bits;

   for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_map
      localparam int ROW     = gi / WIDTH;
      localparam int COL_RAW = gi % WIDTH;
      localparam int COL     = (SERPENTINE && (ROW % 2 == 1)) ? (WIDTH - 1 - COL_RAW) : COL_RAW;
      assign strip_bits[gi] = shadow_q[63 - (ROW * WIDTH + COL)];
   end

   logic [5:0]  lookup_idx;
   logic [31:0] lookup_word;

   // First beat presents index_q itself; later beats present the successor.
   assign lookup_idx  = valid_q ? (index_q + 6'd1) : index_q;
   assign lookup_word = (strip_bits[lookup_idx] ? fg_q : bg_q) | 32'hE000_0000;

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      fg_d     = fg_q;
      bg_d     = bg_q;
      shadow_d = shadow_q;
      busy_d   = busy_q;
      valid_d  = valid_q;
      data_d   = data_q;
      index_d  = index_q;
      last_d   = last_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               sel_d   = (int'(glyph_sel) < NUM_GLYPHS) ? glyph_sel : 2'd0;
               fg_d    = fg_color;
               bg_d    = bg_color;
               busy_d  = 1'b1;
            end
         end
         S_LOAD: begin
            shadow_d = GLYPH_ROM[sel_q];
            index_d  = 6'd0;
            state_d  = S_STREAM;
         end
         S_STREAM: begin
            if (!valid_q) begin
               valid_d = 1'b1;
               data_d  = lookup_word;
               last_d  = (lookup_idx == LAST_IDX);
            end else if (pix_ready) begin
               if (last_q) begin
                  state_d = S_IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  index_d = 6'd0;
               end else begin
                  index_d = lookup_idx;
                  data_d  = lookup_word;
                  last_d  = (lookup_idx == LAST_IDX);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         sel_q    <= 2'd0;
         fg_q     <= 32'd0;
         bg_q     <= 32'd0;
         shadow_q <= 64'd0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         data_q   <= 32'd0;
         index_q  <= 6'd0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         fg_q     <= fg_d;
         bg_q     <= bg_d;
         shadow_q <= shadow_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         index_q  <= index_d;
         last_q   <= last_d;
         done_q   <= done_d;
      end
   end

   assign busy      = busy_q;
   assign pix_valid = valid_q;
   assign pix_data  = data_q;
   assign pix_index = index_q;
   assign pix_last  = last_q;
   assign done      = done_q;

endmodule

// File: tb/tb_matrix_glyph_source.sv
// Directed bench for matrix_glyph_source: three instances (linear, serpentine,
// two-glyph ROM) share stimulus and are compared against hand-derived pixel words.
module tb_matrix_glyph_source;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic pix_ready = 1'b0;
   logic [1:0] glyph_sel = 2'd0;
   logic [31:0] fg_color = 32'd0;
   logic [31:0] bg_color = 32'd0;

   logic [2:0] busy, pv, pl, dn;
   logic [2:0][31:0] pd;
   logic [2:0][5:0] pi;

   int n_checks = 0;
   int n_pass = 0;

   typedef struct {
      int fno;
      int d;
      int idx;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   matrix_glyph_source #(.WIDTH(8), .HEIGHT(8), .NUM_GLYPHS(4), .SERPENTINE(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .glyph_sel(glyph_sel),
      .fg_color(fg_color), .bg_color(bg_color), .busy(busy[0]),
      .pix_valid(pv[0]), .pix_ready(pix_ready), .pix_data(pd[0]),
      .pix_index(pi[0]), .pix_last(pl[0]), .done(dn[0]));

   matrix_glyph_source #(.WIDTH(8), .HEIGHT(8), .NUM_GLYPHS(4), .SERPENTINE(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .glyph_sel(glyph_sel),
      .fg_color(fg_color), .bg_color(bg_color), .busy(busy[1]),
      .pix_valid(pv[1]), .pix_ready(pix_ready), .pix_data(pd[1]),
      .pix_index(pi[1]), .pix_last(pl[1]), .done(dn[1]));

   matrix_glyph_source #(.WIDTH(8), .HEIGHT(8), .NUM_GLYPHS(2), .SERPENTINE(1'b0)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .glyph_sel(glyph_sel),
      .fg_color(fg_color), .bg_color(bg_color), .busy(busy[2]),
      .pix_valid(pv[2]), .pix_ready(pix_ready), .pix_data(pd[2]),
      .pix_index(pi[2]), .pix_last(pl[2]), .done(dn[2]));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [63:0] glyph_word(input int g);
      case (g)
         1: return 64'h0706063E66663B00;
         2: return 64'h00001E3303331E00;
         3: return 64'h3830303E33336E00;
         default: return 64'h0000780C7CCC7600;
      endcase
   endfunction

   // Instance 1 is serpentine; instance 2 only populates glyphs 0 and 1.
   function automatic logic [31:0] exp_pix(input int d, input int sel, input int n,
                                           input logic [31:0] fg, input logic [31:0] bg);
      int g, r, c, col;
      logic [63:0] w;
      g   = (d == 2 && sel >= 2) ? 0 : sel;
      r   = n / 8;
      c   = n % 8;
      col = (d == 1 && (r % 2) == 1) ? 7 - c : c;
      w   = glyph_word(g);
      return {3'b111, (w[63 - (r * 8 + col)] ? fg[28:0] : bg[28:0])};
   endfunction

   task automatic run_frame(input int fno, input int sel, input logic [31:0] fg,
                            input logic [31:0] bg, input bit stall, input bit midstart,
                            input int rst_at);
      int cnt;
      int cyc;
      int stalls;
      cnt = 0;
      cyc = 0;
      stalls = 0;
      pix_ready = 1'b1;
      start = 1'b1;
      glyph_sel = 2'(sel);
      fg_color = fg;
      bg_color = bg;
      @(negedge clk);
      start = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("f%0d_d%0d_busy_after_start", fno, d), busy[d], 1);
         chk($sformatf("f%0d_d%0d_valid_early1", fno, d), pv[d], 0);
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++)
         chk($sformatf("f%0d_d%0d_valid_early2", fno, d), pv[d], 0);
      @(negedge clk);
      while (cnt < 64 && cyc < 300) begin
         cyc++;
         start = 1'b0;
         if (cnt == rst_at) begin
            rst = 1'b1;
            #1;
            for (int d = 0; d < 3; d++) begin
               chk($sformatf("f%0d_d%0d_rst_valid", fno, d), pv[d], 0);
               chk($sformatf("f%0d_d%0d_rst_busy", fno, d), busy[d], 0);
               chk($sformatf("f%0d_d%0d_rst_index", fno, d), pi[d], 0);
            end
            @(negedge clk);
            rst = 1'b0;
            repeat (3) begin
               for (int d = 0; d < 3; d++) begin
                  chk($sformatf("f%0d_d%0d_rst_no_done", fno, d), dn[d], 0);
                  chk($sformatf("f%0d_d%0d_rst_idle", fno, d), pv[d], 0);
               end
               @(negedge clk);
            end
            $display("frame %0d reset at idx %0d", fno, cnt);
            return;
         end
         if (stall && cnt == 10 && stalls < 5) begin
            pix_ready = 1'b0;
            stalls++;
            for (int d = 0; d < 3; d++) begin
               chk($sformatf("f%0d_d%0d_stall_valid", fno, d), pv[d], 1);
               chk($sformatf("f%0d_d%0d_stall_idx", fno, d), pi[d], 10);
               chk($sformatf("f%0d_d%0d_stall_data", fno, d), pd[d], exp_pix(d, sel, 10, fg, bg));
            end
            $display("frame %0d stall %0d idx %0d data %08h", fno, stalls, pi[0], pd[0]);
         end else begin
            pix_ready = 1'b1;
            for (int d = 0; d < 3; d++) begin
               chk($sformatf("f%0d_d%0d_i%0d_valid", fno, d, cnt), pv[d], 1);
               chk($sformatf("f%0d_d%0d_i%0d_idx", fno, d, cnt), pi[d], cnt);
               chk($sformatf("f%0d_d%0d_i%0d_data", fno, d, cnt), pd[d], exp_pix(d, sel, cnt, fg, bg));
               chk($sformatf("f%0d_d%0d_i%0d_last", fno, d, cnt), pl[d], (cnt == 63));
            end
            foreach (vecs[k])
               if (vecs[k].fno == fno && vecs[k].idx == cnt)
                  chk($sformatf("f%0d_d%0d_i%0d_hand", fno, vecs[k].d, cnt), pd[vecs[k].d], vecs[k].exp);
            $display("frame %0d idx %0d data %08h %08h %08h", fno, cnt, pd[0], pd[1], pd[2]);
            cnt++;
         end
         if (midstart && cnt == 33) begin
            start = 1'b1;
            glyph_sel = 2'd1;
            fg_color = 32'h0000_0001;
            bg_color = 32'h0000_0002;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk($sformatf("f%0d_transfer_count", fno), cnt, 64);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("f%0d_d%0d_done_pulse", fno, d), dn[d], 1);
         chk($sformatf("f%0d_d%0d_busy_end", fno, d), busy[d], 0);
         chk($sformatf("f%0d_d%0d_valid_end", fno, d), pv[d], 0);
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("f%0d_d%0d_done_once", fno, d), dn[d], 0);
         chk($sformatf("f%0d_d%0d_idle_after", fno, d), busy[d], 0);
      end
   endtask

   initial begin
      vecs.push_back('{1, 0, 0,  32'hF0000000});
      vecs.push_back('{1, 0, 15, 32'hF0000000});
      vecs.push_back('{1, 0, 16, 32'hF0000000});
      vecs.push_back('{1, 0, 17, 32'hF00F0000});
      vecs.push_back('{1, 0, 20, 32'hF00F0000});
      vecs.push_back('{1, 0, 21, 32'hF0000000});
      vecs.push_back('{1, 0, 28, 32'hF00F0000});
      vecs.push_back('{1, 1, 16, 32'hF0000000});
      vecs.push_back('{1, 1, 18, 32'hF00F0000});
      vecs.push_back('{1, 1, 24, 32'hF0000000});
      vecs.push_back('{1, 1, 26, 32'hF00F0000});
      vecs.push_back('{1, 1, 28, 32'hF0000000});
      vecs.push_back('{2, 0, 10, 32'hF0000000});
      vecs.push_back('{2, 0, 29, 32'hF00F0000});
      vecs.push_back('{3, 0, 16, 32'hE0000000});
      vecs.push_back('{3, 0, 17, 32'hE000FF00});
      vecs.push_back('{3, 0, 63, 32'hE0000000});
      vecs.push_back('{4, 2, 16, 32'hEABCDEF0});
      vecs.push_back('{4, 2, 17, 32'hF2345678});
      vecs.push_back('{4, 0, 0,  32'hEABCDEF0});
      vecs.push_back('{4, 0, 2,  32'hF2345678});
      vecs.push_back('{6, 0, 16, 32'hF0000000});
      vecs.push_back('{6, 0, 19, 32'hF00F0000});
      vecs.push_back('{6, 1, 24, 32'hF00F0000});
      vecs.push_back('{6, 1, 26, 32'hF0000000});

      @(negedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset_d%0d_busy", d), busy[d], 0);
         chk($sformatf("reset_d%0d_valid", d), pv[d], 0);
         chk($sformatf("reset_d%0d_last", d), pl[d], 0);
         chk($sformatf("reset_d%0d_done", d), dn[d], 0);
         chk($sformatf("reset_d%0d_data", d), pd[d], 0);
         chk($sformatf("reset_d%0d_index", d), pi[d], 0);
      end
      rst = 1'b0;
      @(negedge clk);

      run_frame(1, 0, 32'hF00F0000, 32'hF0000000, 1'b0, 1'b0, -1);
      run_frame(2, 0, 32'hF00F0000, 32'hF0000000, 1'b1, 1'b0, -1);
      run_frame(3, 0, 32'h0000FF00, 32'h00000000, 1'b0, 1'b0, -1);
      run_frame(4, 3, 32'h12345678, 32'h0ABCDEF0, 1'b0, 1'b1, -1);
      run_frame(5, 1, 32'hF00F0000, 32'hF0000000, 1'b0, 1'b0, 30);
      run_frame(6, 2, 32'hF00F0000, 32'hF0000000, 1'b0, 1'b0, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
